// File: rtl/rv32i_lsu_pkg.sv
// Shared constants for the rv32i load/store stage: opcode/stall indices, widths,
// funct3 access sizes and the LSU state encoding (stands in for rv32i_header.vh).
package rv32i_lsu_pkg;

  localparam int OPCODE_WIDTH    = 11;
  localparam int EXCEPTION_WIDTH = 4;
  localparam int STALL_WIDTH     = 5;

  localparam int OPC_RTYPE = 0;
  localparam int OPC_LOAD  = 2;
  localparam int OPC_STORE = 3;

  localparam int STL_WRITEBACK = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_H, F3_HU: is_misaligned = lo[0];
      F3_W:        is_misaligned = (lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_format.sv
// Combinational data formatting for the LSU: store lane replication / byte select
// and load byte/half extraction with sign or zero extension.
module rv32i_lsu_format
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_sel,
  output logic [31:0] o_st_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_lo,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    o_st_sel  = 4'b1111;
    o_st_data = i_st_data;
    case (i_st_funct3)
      F3_B, F3_BU: begin
        o_st_sel  = 4'b0001 << i_st_lo;
        o_st_data = {4{i_st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        o_st_sel  = i_st_lo[1] ? 4'b1100 : 4'b0011;
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_lo)
      2'd0:    ld_byte = i_ld_word[7:0];
      2'd1:    ld_byte = i_ld_word[15:8];
      2'd2:    ld_byte = i_ld_word[23:16];
      default: ld_byte = i_ld_word[31:24];
    endcase
    ld_half = i_ld_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  always_comb begin
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    o_ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   o_ld_data = {24'd0, ld_byte};
      F3_HU:   o_ld_data = {16'd0, ld_half};
      F3_W:    o_ld_data = i_ld_word;
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// rv32i memory-access stage: one pipelined-Wishbone transaction per LOAD/STORE.
// Optional misaligned-access trap is enabled by defining RV32I_MISALIGN_TRAP_EN.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [31:0]                i_y,
  input  logic [31:0]                i_rs2,
  input  logic [2:0]                 i_funct3,
  input  logic [OPCODE_WIDTH-1:0]    i_opcode,
  input  logic [EXCEPTION_WIDTH-1:0] i_exception,
  input  logic [31:0]                i_pc,
  input  logic [4:0]                 i_rd_addr,
  input  logic [31:0]                i_rd,
  input  logic                       i_wr_rd,
  input  logic                       i_rd_valid,
  output logic [OPCODE_WIDTH-1:0]    o_opcode,
  output logic [EXCEPTION_WIDTH-1:0] o_exception,
  output logic [31:0]                o_pc,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_rd,
  output logic                       o_wr_rd,
  output logic                       o_rd_valid,
  output logic [31:0]                o_y,
  output logic [31:0]                o_data_load,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic                       o_wb_we,
  output logic [31:0]                o_wb_addr,
  output logic [31:0]                o_wb_data,
  output logic [3:0]                 o_wb_sel,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_stall,
  input  logic [31:0]                i_wb_data,
  output logic                       o_misaligned_load,
  output logic                       o_misaligned_store,
  input  logic                       i_ce,
  output logic                       o_ce,
  input  logic [STALL_WIDTH-1:0]     i_stall,
  output logic                       o_stall,
  input  logic                       i_flush,
  output logic                       o_flush,
  output lsu_state_e                 o_lsu_state
);

  // Upstream handshake: an instruction is taken on a rising edge where accept is
  // high; upstream holds its outputs while o_stall is high, and o_ce marks a valid
  // result for writeback for exactly the cycles it is high.
  lsu_state_e state_q, state_d;
  logic ce_q, ce_d, cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0] sel_q, sel_d;
  logic mis_ld_q, mis_ld_d, mis_st_q, mis_st_d, flush_seen_q, flush_seen_d;

  logic [OPCODE_WIDTH-1:0]    opcode_q;
  logic [EXCEPTION_WIDTH-1:0] exception_q;
  logic [31:0] pc_q, rd_q, y_q;
  logic [4:0]  rd_addr_q;
  logic        wr_rd_q, rd_valid_q;
  logic [2:0]  funct3_q;

  logic memop, accept, misalign, launch, wb_hold, done, keep;
  logic [3:0]  fmt_sel;
  logic [31:0] fmt_wdata, fmt_load;
  logic        unused_stall;

  assign wb_hold = i_stall[STL_WRITEBACK];
  assign memop   = i_opcode[OPC_LOAD] | i_opcode[OPC_STORE];
  assign accept  = i_ce && !wb_hold && (state_q == LSU_IDLE);
`ifdef RV32I_MISALIGN_TRAP_EN
  assign misalign = memop && is_misaligned(i_funct3, i_y[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign launch = accept && memop && !i_flush && !misalign;
  assign done   = ((state_q == LSU_REQ) && !i_wb_stall && i_wb_ack) ||
                  ((state_q == LSU_WAIT) && i_wb_ack);
  // A flush seen at any point of the transaction suppresses its result.
  assign keep   = !(flush_seen_q || i_flush);
  assign unused_stall = ^{i_stall[STL_WRITEBACK-1:0]};

  rv32i_lsu_format u_format (
    .i_st_funct3 (i_funct3),
    .i_st_lo     (i_y[1:0]),
    .i_st_data   (i_rs2),
    .o_st_sel    (fmt_sel),
    .o_st_data   (fmt_wdata),
    .i_ld_funct3 (funct3_q),
    .i_ld_lo     (y_q[1:0]),
    .i_ld_word   (i_wb_data),
    .o_ld_data   (fmt_load)
  );

  always_comb begin
    state_d      = state_q;
    ce_d         = ce_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    load_d       = load_q;
    mis_ld_d     = mis_ld_q;
    mis_st_d     = mis_st_q;
    flush_seen_d = flush_seen_q;
    case (state_q)
      LSU_IDLE: begin
        if (!wb_hold) begin
          ce_d     = accept && !i_flush && !launch;
          mis_ld_d = accept && !i_flush && misalign && i_opcode[OPC_LOAD];
          mis_st_d = accept && !i_flush && misalign && i_opcode[OPC_STORE];
        end
        if (launch) begin
          state_d      = LSU_REQ;
          cyc_d        = 1'b1;
          stb_d        = 1'b1;
          we_d         = i_opcode[OPC_STORE];
          addr_d       = {i_y[31:2], 2'b00};
          wdata_d      = fmt_wdata;
          sel_d        = fmt_sel;
          flush_seen_d = 1'b0;
        end
      end
      LSU_REQ: begin
        ce_d         = 1'b0;
        mis_ld_d     = 1'b0;
        mis_st_d     = 1'b0;
        flush_seen_d = flush_seen_q | i_flush;
        if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        ce_d         = 1'b0;
        mis_ld_d     = 1'b0;
        mis_st_d     = 1'b0;
        flush_seen_d = flush_seen_q | i_flush;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (done) begin
      state_d = LSU_IDLE;
      cyc_d   = 1'b0;
      ce_d    = keep;
      if (keep) load_d = fmt_load;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= LSU_IDLE;
      ce_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      sel_q        <= 4'd0;
      load_q       <= 32'd0;
      mis_ld_q     <= 1'b0;
      mis_st_q     <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      load_q       <= load_d;
      mis_ld_q     <= mis_ld_d;
      mis_st_q     <= mis_st_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opcode_q    <= '0;
      exception_q <= '0;
      pc_q        <= 32'd0;
      rd_addr_q   <= 5'd0;
      rd_q        <= 32'd0;
      wr_rd_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      y_q         <= 32'd0;
      funct3_q    <= 3'd0;
    end else if (accept) begin
      opcode_q    <= i_opcode;
      exception_q <= i_exception;
      pc_q        <= i_pc;
      rd_addr_q   <= i_rd_addr;
      rd_q        <= i_rd;
      wr_rd_q     <= i_wr_rd;
      rd_valid_q  <= i_rd_valid;
      y_q         <= i_y;
      funct3_q    <= i_funct3;
    end
  end

  assign o_opcode           = opcode_q;
  assign o_exception        = exception_q;
  assign o_pc               = pc_q;
  assign o_rd_addr          = rd_addr_q;
  assign o_rd               = rd_q;
  assign o_wr_rd            = wr_rd_q;
  assign o_rd_valid         = rd_valid_q;
  assign o_y                = y_q;
  assign o_data_load        = load_q;
  assign o_wb_cyc           = cyc_q;
  assign o_wb_stb           = stb_q;
  assign o_wb_we            = we_q;
  assign o_wb_addr          = addr_q;
  assign o_wb_data          = wdata_q;
  assign o_wb_sel           = sel_q;
  assign o_misaligned_load  = mis_ld_q;
  assign o_misaligned_store = mis_st_q;
  assign o_ce               = ce_q;
  assign o_flush            = i_flush;
  assign o_lsu_state        = state_q;
  // The ack term lets upstream advance on the same edge that completes the access.
  assign o_stall = ((state_q != LSU_IDLE) && !i_wb_ack) || launch || wb_hold;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed scenarios plus randomized loads/stores
// against a byte-addressed reference memory.
module tb_rv32i_lsu;
  import rv32i_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] i_y, i_rs2, i_pc, i_rd, i_wb_data;
  logic [2:0]  i_funct3;
  logic [OPCODE_WIDTH-1:0]    i_opcode, o_opcode;
  logic [EXCEPTION_WIDTH-1:0] i_exception, o_exception;
  logic [4:0]  i_rd_addr, o_rd_addr;
  logic        i_wr_rd, i_rd_valid, o_wr_rd, o_rd_valid;
  logic [31:0] o_pc, o_rd, o_y, o_data_load, o_wb_addr, o_wb_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack, i_wb_stall;
  logic [3:0]  o_wb_sel;
  logic        o_misaligned_load, o_misaligned_store;
  logic        i_ce, o_ce, o_stall, i_flush, o_flush;
  logic [STALL_WIDTH-1:0] i_stall;
  lsu_state_e  dbg_state;

  rv32i_lsu dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
    .i_opcode(i_opcode), .i_exception(i_exception), .i_pc(i_pc), .i_rd_addr(i_rd_addr),
    .i_rd(i_rd), .i_wr_rd(i_wr_rd), .i_rd_valid(i_rd_valid),
    .o_opcode(o_opcode), .o_exception(o_exception), .o_pc(o_pc), .o_rd_addr(o_rd_addr),
    .o_rd(o_rd), .o_wr_rd(o_wr_rd), .o_rd_valid(o_rd_valid), .o_y(o_y),
    .o_data_load(o_data_load), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
    .o_misaligned_load(o_misaligned_load), .o_misaligned_store(o_misaligned_store),
    .i_ce(i_ce), .o_ce(o_ce), .i_stall(i_stall), .o_stall(o_stall),
    .i_flush(i_flush), .o_flush(o_flush), .o_lsu_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bus_mem [16];
  logic [7:0]  ref_mem [64];

  int          ob_stall, ob_stb, ob_ce;
  logic        ob_cyc, ob_we, ob_timeout, ob_mis_ld, ob_mis_st;
  logic [31:0] ob_addr, ob_wdata, ob_load, ob_y, ob_pc;
  logic [3:0]  ob_sel;
  logic [4:0]  ob_rd_addr;
  logic [EXCEPTION_WIDTH-1:0] ob_exc;
  logic [31:0] drv_pc;
  logic [4:0]  drv_rd_addr;
  logic [EXCEPTION_WIDTH-1:0] drv_exc;

  localparam logic [OPCODE_WIDTH-1:0] OP_ALU   = OPCODE_WIDTH'(1) << OPC_RTYPE;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(1) << OPC_LOAD;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(1) << OPC_STORE;

  // ---------------- driver: one instruction plus a Wishbone slave ----------------
  // n_stall: cycles the slave stalls stb; n_wait: cycles from stb acceptance to ack.
  task automatic drive_op(input logic [OPCODE_WIDTH-1:0] opc, input logic [2:0] f3,
                          input logic [31:0] y, input logic [31:0] rs2,
                          input int n_stall, input int n_wait, input bit flush_wait,
                          input bit bus);
    bit accepted_bus = 0;
    bit acked = 0;
    int stall_left = n_stall;
    int wait_left = 0;
    int post = 0;
    ob_stall = 0; ob_stb = 0; ob_ce = 0; ob_cyc = 0; ob_we = 0;
    ob_mis_ld = 0; ob_mis_st = 0; ob_addr = '0; ob_wdata = '0; ob_sel = '0;
    ob_load = '0; ob_y = '0; ob_pc = '0; ob_rd_addr = '0; ob_exc = '0;
    i_opcode = opc; i_funct3 = f3; i_y = y; i_rs2 = rs2;
    drv_pc = $urandom; drv_rd_addr = 5'($urandom); drv_exc = EXCEPTION_WIDTH'($urandom);
    i_pc = drv_pc; i_rd_addr = drv_rd_addr; i_exception = drv_exc;
    i_rd = $urandom; i_wr_rd = 1'b1; i_rd_valid = 1'b1;
    i_ce = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) i_ce = 1'b0;
      i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_flush = 1'b0;
      if (!accepted_bus && o_wb_stb) begin
        if (stall_left > 0) begin
          i_wb_stall = 1'b1;
          stall_left--;
        end else begin
          accepted_bus = 1;
          wait_left = n_wait;
          ob_addr = o_wb_addr; ob_sel = o_wb_sel; ob_we = o_wb_we; ob_wdata = o_wb_data;
          if (o_wb_we)
            for (int k = 0; k < 4; k++)
              if (o_wb_sel[k]) bus_mem[o_wb_addr[5:2]][8*k +: 8] = o_wb_data[8*k +: 8];
          if (n_wait == 0) begin i_wb_ack = 1'b1; acked = 1; end
        end
      end else if (accepted_bus && !acked) begin
        if (flush_wait && wait_left == n_wait) i_flush = 1'b1;
        wait_left--;
        if (wait_left == 0) begin i_wb_ack = 1'b1; acked = 1; end
      end
      i_wb_data = bus_mem[o_wb_addr[5:2]];
      @(negedge clk);
      if (o_stall) ob_stall++;
      if (o_wb_stb) ob_stb++;
      if (o_wb_cyc) ob_cyc = 1'b1;
      if (o_misaligned_load) ob_mis_ld = 1'b1;
      if (o_misaligned_store) ob_mis_st = 1'b1;
      if (o_ce) begin
        ob_ce++; ob_load = o_data_load; ob_y = o_y; ob_pc = o_pc;
        ob_rd_addr = o_rd_addr; ob_exc = o_exception;
      end
      @(posedge clk); #1;
      if (acked || !bus) post++;
      if (post >= 3) break;
    end
    i_ce = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_flush = 1'b0;
    ob_timeout = bus && !acked;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (o_ce !== 1'b0) begin mismatched++; $display("FAIL reset_ce: got %b want 0", o_ce); end
    compared++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin mismatched++; $display("FAIL reset_bus: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_we}); end
    compared++; if (o_wb_sel !== 4'd0) begin mismatched++; $display("FAIL reset_sel: got %h want 0", o_wb_sel); end
    compared++; if (o_data_load !== 32'd0) begin mismatched++; $display("FAIL reset_load: got %h want 0", o_data_load); end
    compared++; if ({o_misaligned_load, o_misaligned_store} !== 2'b00) begin mismatched++; $display("FAIL reset_mis: got %b want 00", {o_misaligned_load, o_misaligned_store}); end
    compared++; if (dbg_state !== LSU_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    drive_op(OP_STORE, F3_W, 32'h100, 32'hDEADBEEF, 0, 1, 0, 1);
    compared++; if (ob_sel !== 4'b1111) begin mismatched++; $display("FAIL sw_sel: got %b want 1111", ob_sel); end
    compared++; if (ob_addr !== 32'h100) begin mismatched++; $display("FAIL sw_addr: got %h want 100", ob_addr); end
    compared++; if (ob_we !== 1'b1) begin mismatched++; $display("FAIL sw_we: got %b want 1", ob_we); end
    compared++; if (ob_wdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL sw_data: got %h want deadbeef", ob_wdata); end
    compared++; if (ob_stall != 2) begin mismatched++; $display("FAIL sw_stall_cycles: got %0d want 2", ob_stall); end
    compared++; if (ob_ce != 1) begin mismatched++; $display("FAIL sw_ce_pulse: got %0d want 1", ob_ce); end
  endtask

  task automatic test_load_byte();
    bus_mem[0] = 32'h80FF_FF00;
    drive_op(OP_LOAD, F3_B, 32'h203, 32'h0, 0, 1, 0, 1);
    compared++; if (ob_load !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL lb_data: got %h want ffffff80", ob_load); end
    compared++; if ({ob_we, ob_addr} !== {1'b0, 32'h200}) begin mismatched++; $display("FAIL lb_bus: got we=%b addr=%h want we=0 addr=200", ob_we, ob_addr); end
    drive_op(OP_LOAD, F3_BU, 32'h203, 32'h0, 0, 1, 0, 1);
    compared++; if (ob_load !== 32'h0000_0080) begin mismatched++; $display("FAIL lbu_data: got %h want 00000080", ob_load); end
  endtask

  task automatic test_store_half_stall();
    drive_op(OP_STORE, F3_H, 32'h202, 32'hABCD_1234, 3, 1, 0, 1);
    compared++; if (ob_stb != 4) begin mismatched++; $display("FAIL sh_stb_cycles: got %0d want 4", ob_stb); end
    compared++; if (ob_sel !== 4'b1100) begin mismatched++; $display("FAIL sh_sel: got %b want 1100", ob_sel); end
    compared++; if (ob_wdata !== 32'h1234_1234) begin mismatched++; $display("FAIL sh_data: got %h want 12341234", ob_wdata); end
    compared++; if (ob_ce != 1 || ob_timeout) begin mismatched++; $display("FAIL sh_done: got ce=%0d timeout=%b want ce=1 timeout=0", ob_ce, ob_timeout); end
  endtask

  task automatic test_non_memop();
    logic [31:0] y = $urandom;
    drive_op(OP_ALU, F3_W, y, $urandom, 0, 0, 0, 0);
    compared++; if (ob_ce != 1) begin mismatched++; $display("FAIL alu_ce: got %0d want 1", ob_ce); end
    compared++; if (ob_y !== y) begin mismatched++; $display("FAIL alu_y: got %h want %h", ob_y, y); end
    compared++; if ({ob_pc, ob_rd_addr, ob_exc} !== {drv_pc, drv_rd_addr, drv_exc}) begin mismatched++; $display("FAIL alu_passthru: got pc=%h rd=%0d exc=%h want pc=%h rd=%0d exc=%h", ob_pc, ob_rd_addr, ob_exc, drv_pc, drv_rd_addr, drv_exc); end
    compared++; if (ob_cyc !== 1'b0 || ob_stall != 0) begin mismatched++; $display("FAIL alu_no_bus: got cyc=%b stall=%0d want 0/0", ob_cyc, ob_stall); end
  endtask

  task automatic test_flush_wait();
    bus_mem[1] = 32'h1111_2222;
    drive_op(OP_LOAD, F3_W, 32'h04, 32'h0, 0, 1, 0, 1);
    compared++; if (ob_load !== 32'h1111_2222) begin mismatched++; $display("FAIL lw_data: got %h want 11112222", ob_load); end
    bus_mem[1] = 32'h3333_4444;
    drive_op(OP_LOAD, F3_W, 32'h04, 32'h0, 1, 3, 1, 1);
    compared++; if (ob_ce != 0) begin mismatched++; $display("FAIL flush_ce: got %0d want 0", ob_ce); end
    compared++; if (ob_cyc !== 1'b1 || ob_timeout) begin mismatched++; $display("FAIL flush_bus_done: got cyc=%b timeout=%b want 1/0", ob_cyc, ob_timeout); end
    @(negedge clk);
    compared++; if (o_data_load !== 32'h1111_2222) begin mismatched++; $display("FAIL flush_load_kept: got %h want 11112222", o_data_load); end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef RV32I_MISALIGN_TRAP_EN
    drive_op(OP_LOAD, F3_W, 32'h101, 32'h0, 0, 1, 0, 0);
    compared++; if (ob_cyc !== 1'b0) begin mismatched++; $display("FAIL mis_no_cyc: got %b want 0", ob_cyc); end
    compared++; if (ob_mis_ld !== 1'b1 || ob_mis_st !== 1'b0) begin mismatched++; $display("FAIL mis_flag: got ld=%b st=%b want 1/0", ob_mis_ld, ob_mis_st); end
    compared++; if (ob_ce != 1) begin mismatched++; $display("FAIL mis_ce: got %0d want 1", ob_ce); end
`else
    drive_op(OP_LOAD, F3_W, 32'h101, 32'h0, 0, 1, 0, 1);
    compared++; if (ob_addr !== 32'h100 || ob_timeout) begin mismatched++; $display("FAIL mis_addr: got %h timeout=%b want 100", ob_addr, ob_timeout); end
    compared++; if (ob_mis_ld !== 1'b0) begin mismatched++; $display("FAIL mis_flag: got %b want 0", ob_mis_ld); end
`endif
  endtask

  task automatic test_ack_idle();
    bus_mem[2] = 32'h5555_AAAA;
    drive_op(OP_LOAD, F3_W, 32'h08, 32'h0, 0, 1, 0, 1);
    compared++; if (ob_load !== 32'h5555_AAAA) begin mismatched++; $display("FAIL idle_pre_load: got %h want 5555aaaa", ob_load); end
    for (int c = 0; c < 3; c++) begin
      i_wb_ack = 1'b1; i_wb_data = $urandom;
      @(negedge clk);
      compared++; if (o_ce !== 1'b0 || o_stall !== 1'b0) begin mismatched++; $display("FAIL idle_ack_ce: got ce=%b stall=%b want 0/0", o_ce, o_stall); end
      @(posedge clk); #1;
    end
    i_wb_ack = 1'b0;
    @(negedge clk);
    compared++; if (o_data_load !== 32'h5555_AAAA || dbg_state !== LSU_IDLE) begin mismatched++; $display("FAIL idle_ack_ignored: got load=%h state=%0d want 5555aaaa IDLE", o_data_load, dbg_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    i_opcode = OP_LOAD; i_funct3 = F3_W; i_y = 32'h40; i_ce = 1'b1; i_wb_stall = 1'b1;
    @(posedge clk); #1;
    i_ce = 1'b0;
    @(negedge clk);
    compared++; if ({o_wb_cyc, o_wb_stb} !== 2'b11) begin mismatched++; $display("FAIL rst_mid_pre: got %b want 11", {o_wb_cyc, o_wb_stb}); end
    #1 rst_n = 1'b0;
    #1;
    compared++; if ({o_wb_cyc, o_wb_stb} !== 2'b00) begin mismatched++; $display("FAIL rst_mid_async: got %b want 00", {o_wb_cyc, o_wb_stb}); end
    @(negedge clk);
    rst_n = 1'b1; i_wb_stall = 1'b0;
    @(negedge clk);
    compared++; if (dbg_state !== LSU_IDLE || o_ce !== 1'b0) begin mismatched++; $display("FAIL rst_mid_idle: got state=%0d ce=%b want IDLE/0", dbg_state, o_ce); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, y, rs2, v, exp_v;
    logic [2:0] f3;
    int kind, size;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      bus_mem[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = w[8*k +: 8];
    end
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 8);
      f3 = (kind == 0) ? F3_B : (kind == 1) ? F3_H : (kind == 2) ? F3_W :
           (kind == 3) ? F3_BU : (kind == 4) ? F3_HU : (kind == 5) ? F3_B :
           (kind == 6) ? F3_H : F3_W;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      y = 32'($urandom_range(0, 63)) & ~32'(size - 1);
      rs2 = $urandom;
      if (kind == 8) begin
        y = $urandom;
        drive_op(OP_ALU, f3, y, rs2, 0, 0, 0, 0);
        compared++; if (ob_ce != 1 || ob_y !== y) begin mismatched++; $display("FAIL rnd_alu: got ce=%0d y=%h want 1 %h", ob_ce, ob_y, y); end
      end else if (kind >= 5) begin
        for (int k = 0; k < size; k++) ref_mem[y+k] = rs2[8*k +: 8];
        drive_op(OP_STORE, f3, y, rs2, $urandom_range(0, 2), $urandom_range(0, 3), 0, 1);
        exp_v = 32'(((1 << size) - 1) << (y % 4));
        compared++; if (ob_sel !== exp_v[3:0] || ob_ce != 1 || ob_timeout) begin mismatched++; $display("FAIL rnd_store: n=%0d got sel=%b ce=%0d want sel=%b ce=1", n, ob_sel, ob_ce, exp_v[3:0]); end
      end else begin
        v = 32'd0;
        for (int k = 0; k < size; k++) v = v | (32'(ref_mem[y+k]) << (8*k));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
        exp_q.push_back(v);
        drive_op(OP_LOAD, f3, y, rs2, $urandom_range(0, 2), $urandom_range(0, 3), 0, 1);
        exp_v = exp_q.pop_front();
        compared++; if (ob_load !== exp_v || ob_ce != 1 || ob_timeout) begin mismatched++; $display("FAIL rnd_load: n=%0d f3=%0d y=%h got %h ce=%0d want %h", n, f3, y, ob_load, ob_ce, exp_v); end
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    i_y = '0; i_rs2 = '0; i_funct3 = '0; i_opcode = '0; i_exception = '0; i_pc = '0;
    i_rd_addr = '0; i_rd = '0; i_wr_rd = 1'b0; i_rd_valid = 1'b0; i_wb_ack = 1'b0;
    i_wb_stall = 1'b0; i_wb_data = '0; i_ce = 1'b0; i_stall = '0; i_flush = 1'b0;
    for (int i = 0; i < 16; i++) bus_mem[i] = 32'd0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half_stall();
    test_non_memop();
    test_flush_wait();
    test_misalign();
    test_ack_idle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
